// File: rtl/wtime_calc_seq.sv
// -----------------------------------------------------------------------------
// wtime_calc_seq
//
// Sequential waiting-time calculator for the bank-queue datapath. It computes
//   Wtime = floor(TSERV * (Pcount + Tcount - 1) / Tcount)
// with an iterative restoring divider (one quotient bit per clock) behind a
// start/done handshake. The result is saturated to WTIME_W bits, and ovf flags
// the saturation.
//
// Build option:
//   WTIME_ROUND_EN - when defined, (Tcount >> 1) is added to the numerator.
//                    The result then rounds to nearest, with halves rounded up.
//                    Latency, handshake and bypass behaviour are the same in
//                    both builds.
//
// Ports:
//   clk     in   1         system clock, rising edge
//   rst_n   in   1         asynchronous active-low reset
//   start   in   1         request a computation (sampled only in IDLE)
//   Pcount  in   PCOUNT_W  waiting customers, latched on an accepted start
//   Tcount  in   TCOUNT_W  active tellers, latched on an accepted start
//   busy    out  1         high while in DIV or DONE
//   done    out  1         one-cycle pulse; Wtime is valid from this cycle on
//   Wtime   out  WTIME_W   result, held until the next done
//   ovf     out  1         quotient exceeded 2^WTIME_W-1 (updated with Wtime)
//
// Latency, counted from the edge that accepts start:
//   normal path - done is high in cycle NUM_W+1
//   bypass path - done is high in cycle 1 (Tcount==0 or Pcount==0)
// -----------------------------------------------------------------------------
module wtime_calc_seq #(
  parameter int PCOUNT_W = 3,
  parameter int TCOUNT_W = 2,
  parameter int TSERV    = 3,
  parameter int WTIME_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [PCOUNT_W-1:0] Pcount,
  input  logic [TCOUNT_W-1:0] Tcount,
  output logic                busy,
  output logic                done,
  output logic [WTIME_W-1:0]  Wtime,
  output logic                ovf
);

  localparam int NUM_W = PCOUNT_W + TCOUNT_W + 4;
  localparam int CNT_W = $clog2(NUM_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Numerator TSERV*(p+t-1), optionally biased by t/2 for round-to-nearest.
  // With TSERV <= 15 the value always fits in NUM_W bits.
  function automatic logic [NUM_W-1:0] calc_num(
    input logic [PCOUNT_W-1:0] p,
    input logic [TCOUNT_W-1:0] t
  );
    logic [NUM_W-1:0] sum;
    logic [NUM_W-1:0] prod;
    sum  = NUM_W'(p) + NUM_W'(t) - NUM_W'(1);
    prod = NUM_W'(TSERV) * sum;
`ifdef WTIME_ROUND_EN
    prod = prod + NUM_W'(t >> 1);
`endif
    return prod;
  endfunction

  // Clamp the full-width quotient to WTIME_W bits. Returns {ovf, value}.
  function automatic logic [WTIME_W:0] sat_q(input logic [NUM_W-1:0] q);
    logic [WTIME_W:0] r;
    if ((q >> WTIME_W) != '0) begin
      r = {1'b1, {WTIME_W{1'b1}}};
    end else begin
      r = {1'b0, WTIME_W'(q)};
    end
    return r;
  endfunction

  logic [1:0]          state;
  logic [TCOUNT_W-1:0] t_q;
  logic [NUM_W-1:0]    num_q;   // numerator bits shift out the top, quotient bits shift in at the bottom
  logic [TCOUNT_W:0]   rem_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WTIME_W-1:0]  wtime_q;
  logic                ovf_q;

  logic [TCOUNT_W:0]   rem_sh;
  logic [TCOUNT_W:0]   t_ext;
  logic                sub_ok;
  logic [TCOUNT_W:0]   rem_nxt;
  logic [NUM_W-1:0]    q_nxt;
  logic [WTIME_W:0]    sat_nxt;

  // One restoring-division step: shift {rem,num} left and trial-subtract t.
  // A bit shifted out of the top of rem means the shifted value is larger than
  // any t, so that bit alone forces the subtraction. Because rem stays below t,
  // the bit is always 0 in practice.
  always_comb begin
    rem_sh  = {rem_q[TCOUNT_W-1:0], num_q[NUM_W-1]};
    t_ext   = {1'b0, t_q};
    sub_ok  = rem_q[TCOUNT_W] | (rem_sh >= t_ext);
    rem_nxt = rem_sh;
    q_nxt   = {num_q[NUM_W-2:0], 1'b0};
    if (sub_ok) begin
      rem_nxt = rem_sh - t_ext;
      q_nxt   = {num_q[NUM_W-2:0], 1'b1};
    end
    sat_nxt = sat_q(q_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      t_q     <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      wtime_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            t_q <= Tcount;
            if ((Tcount == '0) || (Pcount == '0)) begin
              // Bypass: no customers or no tellers means zero wait.
              num_q   <= '0;
              wtime_q <= '0;
              ovf_q   <= 1'b0;
              state   <= S_DONE;
            end else begin
              num_q <= calc_num(Pcount, Tcount);
              rem_q <= '0;
              cnt_q <= CNT_W'(NUM_W - 1);
              state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          num_q <= q_nxt;
          rem_q <= rem_nxt;
          if (cnt_q == '0) begin
            // The last quotient bit is resolved on this edge, so the output is
            // taken from the step result and is visible together with done.
            {ovf_q, wtime_q} <= sat_nxt;
            state            <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign Wtime = wtime_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_wtime_calc_seq.sv
module tb_wtime_calc_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] Pcount = '0;
  logic [1:0] Tcount = '0;
  logic       busy, done, ovf;
  logic [4:0] Wtime;

  // Saturation instance: WTIME_W=4, TSERV=15
  logic       start_s = 1'b0;
  logic [2:0] Pcount_s = '0;
  logic [1:0] Tcount_s = '0;
  logic       busy_s, done_s, ovf_s;
  logic [3:0] Wtime_s;

  int n_chk = 0;
  int n_fail = 0;

  // Hand-computed legacy table, indexed [T][P], TSERV=3
`ifdef WTIME_ROUND_EN
  int exp_tbl [4][8] = '{
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 3, 6, 9, 12, 15, 18, 21},
    '{0, 3, 5, 6, 8, 9, 11, 12},
    '{0, 3, 4, 5, 6, 7, 8, 9}
  };
`else
  int exp_tbl [4][8] = '{
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 3, 6, 9, 12, 15, 18, 21},
    '{0, 3, 4, 6, 7, 9, 10, 12},
    '{0, 3, 4, 5, 6, 7, 8, 9}
  };
`endif

  wtime_calc_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Pcount(Pcount), .Tcount(Tcount),
    .busy(busy), .done(done), .Wtime(Wtime), .ovf(ovf)
  );

  wtime_calc_seq #(.WTIME_W(4), .TSERV(15)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .Pcount(Pcount_s), .Tcount(Tcount_s),
    .busy(busy_s), .done(done_s), .Wtime(Wtime_s), .ovf(ovf_s)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One computation on the main instance: latency, result, ovf, pulse width.
  task automatic run(input int p, input int t, input int exp_w, input int exp_cyc, input string tag);
    int cyc;
    Pcount = 3'(p);
    Tcount = 2'(t);
    start  = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 30) begin
      tick;
      cyc++;
    end
    chk({tag, " latency"}, cyc, exp_cyc);
    chk({tag, " wtime"}, Wtime, exp_w);
    chk({tag, " ovf"}, ovf, 0);
    tick;
    chk({tag, " done width"}, done, 0);
  endtask

  initial begin
    int cyc;
    int ndone;
    int bq[$];

    // Reset state
    tick;
    tick;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset wtime", Wtime, 0);
    chk("reset ovf", ovf, 0);
    chk("reset busy_s", busy_s, 0);
    rst_n = 1'b1;
    tick;

    // Exhaustive sweep of all (T,P) pairs
    for (int t = 0; t < 4; t++) begin
      for (int p = 0; p < 8; p++) begin
        run(p, t, exp_tbl[t][p], (t == 0 || p == 0) ? 1 : 10,
            $sformatf("sweep T%0d P%0d", t, p));
      end
    end

    // Handshake: extra start pulses in DIV (cycle 3) and DONE (cycle 10) are ignored;
    // inputs changed after acceptance have no effect.
    Pcount = 3'd5;
    Tcount = 2'd3;
    start  = 1'b1;
    tick;
    ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      start = (c == 3 || c == 10);
      if (c == 2) begin
        Pcount = 3'd7;
        Tcount = 2'd1;
      end
      if (c == 4) chk("hs busy in div", busy, 1);
      if (done) begin
        ndone++;
        chk("hs done cycle", c, 10);
        chk("hs wtime", Wtime, 7);
      end
      tick;
    end
    start = 1'b0;
    chk("hs done count", ndone, 1);
    chk("hs idle after", busy, 0);

    // Back-to-back with held start and inputs changing every cycle
    start = 1'b1;
    for (int k = 0; k < 44; k++) begin
      Pcount = 3'((k % 7) + 1);
      Tcount = 2'((k % 3) + 1);
      if (k % 11 == 0) bq.push_back(exp_tbl[(k % 3) + 1][(k % 7) + 1]);
      tick;
      chk($sformatf("b2b done k%0d", k), done, (k % 11 == 9));
      if (done && bq.size() > 0) chk($sformatf("b2b wtime k%0d", k), Wtime, bq.pop_front());
    end
    start = 1'b0;
    chk("b2b all results", bq.size(), 0);
    tick;
    tick;

    // Asynchronous reset mid-DIV aborts the computation
    Pcount = 3'd7;
    Tcount = 2'd1;
    start  = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    chk("rst pre busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async busy", busy, 0);
    chk("rst async wtime", Wtime, 0);
    chk("rst async ovf", ovf, 0);
    chk("rst async done", done, 0);
    tick;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) ndone++;
      tick;
    end
    chk("rst no done", ndone, 0);
    chk("rst wtime held 0", Wtime, 0);

    // Saturation: 15*7/1 = 105 -> 15, ovf
    Pcount_s = 3'd7;
    Tcount_s = 2'd1;
    start_s  = 1'b1;
    tick;
    start_s = 1'b0;
    cyc = 1;
    while (!done_s && cyc < 30) begin
      tick;
      cyc++;
    end
    chk("sat latency", cyc, 10);
    chk("sat wtime", Wtime_s, 15);
    chk("sat ovf", ovf_s, 1);
    tick;
    chk("sat busy after", busy_s, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
